msfsm_mg_engine: RTL and testbench
==================================

# msfsm_mg_engine

Parametrised marked-graph token engine for the synchronous multi-FSM (MSFSM) flow. It implements an arbitrary marked graph in one clocked block: bounded token counters per place, input transitions driven by environment event pulses, and output transitions issued as event pulses. It adds configurable place capacity, output back-pressure, a Mealy/Moore output mode, unexpected-input detection and deadlock detection. It replaces hand-partitioned per-FSM instances plus output AND-ing with a single place-level implementation.

## Interface
- NP, 4: number of places.
- NT, 4: number of transitions; transitions 0..NI-1 are inputs, NI..NT-1 are outputs.
- NI, 1: number of input transitions (1 ≤ NI < NT).
- CW, 2: token counter width; place capacity MAX = 2^CW-1.
- PRE, 16'h4218: NT*NP bits; bit t*NP+p = 1 if place p is in the preset of transition t.
- POST, 16'h8421: NT*NP bits; bit t*NP+p = 1 if place p is in the postset of transition t.
- M0, 8'h40: NP*CW bits; initial marking, place p at [p*CW +: CW].
- MOORE, 0: 0 = Mealy (combinational out_ev), 1 = registered out_ev.
- DLW, 3: deadlock counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_ev  in  NI  input-transition event pulses, one cycle each, sampled on clk.
- out_rdy  in  NT-NI  environment accepts output transition NI+j.
- out_ev  out  NT-NI  output transition NI+j fires.
- enabled  out  NT  per-transition enable, from the registered marking.
- marking  out  NP*CW  current token counts.
- err_unexp  out  1  sticky: input event arrived while its transition was not enabled.
- deadlock  out  1  sticky: enabled == 0 for 2^DLW-1 consecutive cycles.
- cfg_err  out  1  constant 1 if any place lacks exactly one producer and one consumer in PRE/POST.

## Operation
- enabled[t] = every preset place > 0 AND every postset place < MAX. The full check is conservative: a producer is blocked on a full place even if that place's consumer fires in the same cycle.
- fire[t] for inputs = in_ev[t] & enabled[t]. For outputs = enabled[t] & out_rdy[t-NI].
- All fired transitions fire in the same cycle. The marked-graph property (one producer, one consumer per place) guarantees no conflict.
- Per place p: next m[p] = m[p] - fire(consumer) + fire(producer), updated on the clk edge. This can never overflow or underflow.
- in_ev[t] while !enabled[t]: the event is discarded, marking is unchanged, and err_unexp is set on the next edge. Only reset clears it.
- Deadlock counter: increments each cycle while enabled == 0, saturates at 2^DLW-1, and clears on any cycle with enabled != 0. deadlock is set when the counter saturates; only reset clears it.
- MOORE=0: out_ev = fire of the output transitions (combinational from marking and out_rdy).
- MOORE=1: out_ev is a register loaded with the output fire vector. Pulses appear one cycle after the firing edge. Marking behaviour is identical to MOORE=0.
- cfg_err is an elaboration-time constant. Behaviour with cfg_err=1 is undefined.

## Timing
- Reset (reset=0, asynchronous) sets:
  - marking = M0, err_unexp = 0, deadlock = 0, deadlock counter = 0.
  - out_ev = 0 when MOORE=1.
  - When MOORE=0, out_ev = enabled(M0) & out_rdy; the marking does not advance until reset is deasserted.
- Reset asserted mid-operation restores M0 immediately and drops all in-flight events.
- Input latency: in_ev at edge k updates marking at edge k. A successor output transition can fire in cycle k+1 (Mealy) with its out_ev pulse in cycle k+1, or in cycle k+2 (Moore).
- Throughput: one firing per transition per cycle.
- out_rdy low holds the transition. Its tokens stay in place and out_ev stays low.

## Test plan
- Reset with defaults -> marking=8'h40, enabled=4'b0001, out_ev=0, err_unexp=0, deadlock=0, cfg_err=0.
- Mealy, out_rdy=3'b111, single in_ev pulse at cycle 1 -> out_ev=3'b001, 3'b010, 3'b100 in cycles 2, 3, 4; marking back to 8'h40 after the cycle-4 edge.
- Second in_ev in cycle 2 of the previous run (t0 not enabled) -> err_unexp=1 from the next edge, marking unaffected, sequence completes normally.
- out_rdy=3'b101 after in_ev -> marking holds 8'h04 (p1=1), out_ev[1]=0, deadlock stays 0.
- M0=8'h43 (p0 full) -> in_ev blocked, err_unexp=1. M0=8'h00 with DLW=3 -> deadlock rises after the 7th post-reset edge.
- MOORE=1 repeat of scenario 2 -> identical marking trace, out_ev pulses in cycles 3, 4, 5. Assert reset in cycle 3 -> marking=8'h40 and out_ev=0 immediately.

Source files
------------

// File: rtl/msfsm_mg_engine.sv
// msfsm_mg_engine: marked-graph token engine with bounded places, back-pressure and error detection
module msfsm_mg_engine #(
   parameter int               NP    = 4,
   parameter int               NT    = 4,
   parameter int               NI    = 1,
   parameter int               CW    = 2,
   parameter logic [NT*NP-1:0] PRE   = 16'h4218,
   parameter logic [NT*NP-1:0] POST  = 16'h8421,
   parameter logic [NP*CW-1:0] M0    = 8'h40,
   parameter int               MOORE = 0,
   parameter int               DLW   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NI-1:0]       in_ev,
   input  logic [NT-NI-1:0]    out_rdy,
   output logic [NT-NI-1:0]    out_ev,
   output logic [NT-1:0]       enabled,
   output logic [NP*CW-1:0]    marking,
   output logic                err_unexp,
   output logic                deadlock,
   output logic                cfg_err
);
   localparam logic [CW-1:0]  MAX  = '1;
   localparam logic [DLW-1:0] DMAX = '1;

   function automatic logic cfg_check();
      logic bad;
      int   prod;
      int   cons;
      bad = 1'b0;
      for (int p = 0; p < NP; p++) begin
         prod = 0;
         cons = 0;
         for (int t = 0; t < NT; t++) begin
            prod += int'(POST[t*NP+p]);
            cons += int'(PRE[t*NP+p]);
         end
         if (prod != 1 || cons != 1) bad = 1'b1;
      end
      return bad;
   endfunction

   localparam logic CFG = cfg_check();

   logic [NT-1:0]    fire;
   logic [NP*CW-1:0] mark_nxt;
   logic [DLW-1:0]   dl_cnt;
   logic [DLW-1:0]   dl_nxt;

   assign cfg_err = CFG;

   // a transition is enabled when all its preset places hold a token and all postset places have room
   always_comb begin
      enabled = '1;
      for (int t = 0; t < NT; t++)
         for (int p = 0; p < NP; p++) begin
            if (PRE[t*NP+p] && marking[p*CW +: CW] == '0) enabled[t] = 1'b0;
            if (POST[t*NP+p] && marking[p*CW +: CW] == MAX) enabled[t] = 1'b0;
         end
   end

   assign fire = {enabled[NT-1:NI] & out_rdy, enabled[NI-1:0] & in_ev};

   // each place loses a token when its consumer fires and gains one when its producer fires
   always_comb begin
      mark_nxt = marking;
      for (int t = 0; t < NT; t++)
         for (int p = 0; p < NP; p++) begin
            if (PRE[t*NP+p] && fire[t]) mark_nxt[p*CW +: CW] = mark_nxt[p*CW +: CW] - CW'(1);
            if (POST[t*NP+p] && fire[t]) mark_nxt[p*CW +: CW] = mark_nxt[p*CW +: CW] + CW'(1);
         end
   end

   assign dl_nxt = (|enabled) ? '0 : (dl_cnt == DMAX ? dl_cnt : dl_cnt + DLW'(1));

   // marking, sticky error flags and the no-progress counter
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         marking   <= M0;
         err_unexp <= 1'b0;
         dl_cnt    <= '0;
         deadlock  <= 1'b0;
      end else begin
         marking   <= mark_nxt;
         err_unexp <= err_unexp | (|(in_ev & ~enabled[NI-1:0]));
         dl_cnt    <= dl_nxt;
         deadlock  <= deadlock | (dl_nxt == DMAX);
      end

   generate
      if (MOORE != 0) begin : g_moore
         // output pulses delayed one cycle behind the firing edge
         always_ff @(posedge clk or negedge reset)
            if (!reset) out_ev <= '0;
            else        out_ev <= fire[NT-1:NI];
      end else begin : g_mealy
         assign out_ev = fire[NT-1:NI];
      end
   endgenerate
endmodule

// File: tb/tb_msfsm_mg_engine.sv
// tb_msfsm_mg_engine: ring marked-graph token model checked against four engine configurations
module tb_msfsm_mg_engine;
   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_ev = 1'b0;
   logic [2:0]      out_rdy = 3'b111;
   logic [3:0][2:0] oe;
   logic [3:0][3:0] en;
   logic [3:0][7:0] mkw;
   logic [3:0]      eu;
   logic [3:0]      dd;
   logic [3:0]      ce;
   int              checks = 0;
   int              errors = 0;
   int              mk [4][4];
   logic [2:0]      mo [4];
   int              dl [4];
   logic            er [4];
   logic            dk [4];
   logic [3:0]      e;
   logic [2:0]      f;
   logic [2:0]      eo;
   logic            fin;
   logic [7:0]      pm;

   always #5 clk = ~clk;

   msfsm_mg_engine u0 (.clk(clk), .reset(reset), .in_ev(in_ev), .out_rdy(out_rdy), .out_ev(oe[0]),
      .enabled(en[0]), .marking(mkw[0]), .err_unexp(eu[0]), .deadlock(dd[0]), .cfg_err(ce[0]));
   msfsm_mg_engine #(.MOORE(1)) u1 (.clk(clk), .reset(reset), .in_ev(in_ev), .out_rdy(out_rdy), .out_ev(oe[1]),
      .enabled(en[1]), .marking(mkw[1]), .err_unexp(eu[1]), .deadlock(dd[1]), .cfg_err(ce[1]));
   msfsm_mg_engine #(.M0(8'h43)) u2 (.clk(clk), .reset(reset), .in_ev(in_ev), .out_rdy(out_rdy), .out_ev(oe[2]),
      .enabled(en[2]), .marking(mkw[2]), .err_unexp(eu[2]), .deadlock(dd[2]), .cfg_err(ce[2]));
   msfsm_mg_engine #(.M0(8'h00)) u3 (.clk(clk), .reset(reset), .in_ev(in_ev), .out_rdy(out_rdy), .out_ev(oe[3]),
      .enabled(en[3]), .marking(mkw[3]), .err_unexp(eu[3]), .deadlock(dd[3]), .cfg_err(ce[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m0v(input int i, input int p);
      if (i == 2) return p == 0 ? 3 : (p == 3 ? 1 : 0);
      if (i == 3) return 0;
      return p == 3 ? 1 : 0;
   endfunction

   // ring model: transition t takes a token from place (t+3)%4 and puts one in place t, capacity 3
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!reset) begin
            for (int p = 0; p < 4; p++) mk[i][p] = m0v(i, p);
            mo[i] = 3'b000;
            dl[i] = 0;
            er[i] = 1'b0;
            dk[i] = 1'b0;
         end
         for (int t = 0; t < 4; t++) e[t] = mk[i][(t+3)%4] > 0 && mk[i][t] < 3;
         fin = in_ev & e[0];
         f = e[3:1] & out_rdy;
         for (int p = 0; p < 4; p++) pm[p*2 +: 2] = 2'(mk[i][p]);
         eo = (i == 1) ? mo[i] : f;
         chk($sformatf("marking%0d", i), 32'(mkw[i]), 32'(pm));
         chk($sformatf("enabled%0d", i), 32'(en[i]), 32'(e));
         chk($sformatf("out_ev%0d", i), 32'(oe[i]), 32'(eo));
         chk($sformatf("err_unexp%0d", i), 32'(eu[i]), 32'(er[i]));
         chk($sformatf("deadlock%0d", i), 32'(dd[i]), 32'(dk[i]));
         if (reset) begin
            if (fin) begin
               mk[i][3]--;
               mk[i][0]++;
            end
            for (int j = 0; j < 3; j++)
               if (f[j]) begin
                  mk[i][j]--;
                  mk[i][j+1]++;
               end
            mo[i] = f;
            er[i] = er[i] | (in_ev & ~e[0]);
            dl[i] = (e != 0) ? 0 : (dl[i] < 7 ? dl[i] + 1 : 7);
            if (dl[i] == 7) dk[i] = 1'b1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [2:0] rdy);
      reset = 1'b0;
      in_ev = 1'b0;
      out_rdy = rdy;
      repeat (3) cyc();
      reset = 1'b1;
      in_ev = 1'b1;
   endtask

   initial begin
      start(3'b111);
      #1;
      chk("rst_marking", 32'(mkw[0]), 32'h40);
      chk("rst_enabled", 32'(en[0]), 32'h1);
      chk("rst_out_ev", 32'(oe[0]), 32'h0);
      chk("rst_out_ev_moore", 32'(oe[1]), 32'h0);
      chk("rst_err", 32'(eu[0]), 32'h0);
      chk("rst_deadlock", 32'(dd[0]), 32'h0);
      chk("cfg_err", 32'(ce), 32'h0);
      cyc(); in_ev = 1'b0; #1;
      chk("c2_marking", 32'(mkw[0]), 32'h01);
      chk("c2_out_ev", 32'(oe[0]), 32'h1);
      chk("c2_moore", 32'(oe[1]), 32'h0);
      cyc(); #1;
      chk("c3_marking", 32'(mkw[0]), 32'h04);
      chk("c3_out_ev", 32'(oe[0]), 32'h2);
      chk("c3_moore", 32'(oe[1]), 32'h1);
      cyc(); #1;
      chk("c4_marking", 32'(mkw[0]), 32'h10);
      chk("c4_out_ev", 32'(oe[0]), 32'h4);
      chk("c4_moore", 32'(oe[1]), 32'h2);
      cyc(); in_ev = 1'b1; #1;
      chk("c5_marking", 32'(mkw[0]), 32'h40);
      chk("c5_moore", 32'(oe[1]), 32'h4);
      chk("c5_moore_marking", 32'(mkw[1]), 32'h40);
      cyc(); #1;
      chk("r2_err_before", 32'(eu[0]), 32'h0);
      chk("r2_marking1", 32'(mkw[0]), 32'h01);
      cyc(); in_ev = 1'b0; #1;
      chk("r2_err_after", 32'(eu[0]), 32'h1);
      chk("r2_marking2", 32'(mkw[0]), 32'h04);
      chk("dl_edge6", 32'(dd[3]), 32'h0);
      cyc(); #1;
      chk("dl_edge7", 32'(dd[3]), 32'h1);
      cyc(); #1;
      chk("r2_done", 32'(mkw[0]), 32'h40);

      start(3'b101);
      cyc(); in_ev = 1'b0;
      repeat (11) cyc();
      #1;
      chk("bp_marking", 32'(mkw[0]), 32'h04);
      chk("bp_out_ev", 32'(oe[0]), 32'h0);
      chk("bp_deadlock", 32'(dd[0]), 32'h0);

      start(3'b000);
      cyc(); in_ev = 1'b0; #1;
      chk("full_err", 32'(eu[2]), 32'h1);
      chk("full_marking", 32'(mkw[2]), 32'h43);
      chk("full_enabled", 32'(en[2]), 32'h2);

      start(3'b111);
      cyc(); in_ev = 1'b0;
      cyc(); #1;
      chk("mr_moore_out", 32'(oe[1]), 32'h1);
      chk("mr_moore_mark", 32'(mkw[1]), 32'h04);
      reset = 1'b0;
      #1;
      chk("mr_rst_mark", 32'(mkw[1]), 32'h40);
      chk("mr_rst_out", 32'(oe[1]), 32'h0);
      chk("mr_rst_mealy", 32'(mkw[0]), 32'h40);
      repeat (2) cyc();
      reset = 1'b1;
      repeat (4) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
